tff_count_ctrl: RTL and testbench
=================================

TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the width of the controlled toggle-flip-flop bank and the count.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 cfg_valid  input  1  configuration offer; qualifies mod_val.
REQ-005 cfg_ready  output  1  configuration accepted when high with cfg_valid.
REQ-006 mod_val  input  WIDTH  terminal count value; the count range is 0..mod_val.
REQ-007 oneshot  input  1  sampled at start; 1 = stop at first terminal count, 0 = continuous.
REQ-008 start  input  1  single-cycle command: begin or resume counting.
REQ-009 stop  input  1  single-cycle command: pause counting.
REQ-010 step  input  1  advance request; one count per cycle in which step is high while in RUN.
REQ-011 dir  input  1  0 = up, 1 = down; sampled on every step.
REQ-012 t_en  output  WIDTH  toggle-enable vector for the TFF bank, equal to count XOR next count.
REQ-013 count  output  WIDTH  current count, mirroring the TFF bank state.
REQ-014 tc  output  1  one-cycle terminal-count (wrap) pulse.
REQ-015 busy  output  1  high in RUN and PAUSE.
REQ-016 done  output  1  high in DONE.

Function
REQ-017 FSM states: IDLE, RUN, PAUSE, DONE.
REQ-018 The stored terminal value term is updated only when cfg_valid and cfg_ready are both high.
REQ-019 cfg_ready is high only in IDLE or DONE.
REQ-020 A handshake loads term = mod_val when mod_val is nonzero, and term = 2^WIDTH-1 when mod_val is 0.
REQ-021 IDLE/DONE + start -> RUN at the next edge.
- The count loads 0 when dir=0 and term when dir=1.
- oneshot is latched at the same edge.
- t_en is 0 on that load cycle.
REQ-022 RUN + step with dir=0: the count advances per these rules.
- count < term: count+1.
- count == term: count goes to 0 and tc = 1 for that cycle.
REQ-023 RUN + step with dir=1: the count advances per these rules.
- count > 0: count-1.
- count == 0: count goes to term and tc = 1 for that cycle.
REQ-024 t_en is combinational and nonzero only in RUN with step high.
- Value: count XOR the count following that edge.
- Otherwise t_en is all zeros.
REQ-025 tc is combinational, coincident with t_en of the wrapping step; there is zero latency from step to t_en/tc.
REQ-026 With latched oneshot=1, a wrapping step moves the FSM to DONE.
- The count holds the wrapped value.
- Further steps are ignored.
REQ-027 RUN + stop -> PAUSE; the count holds and steps are ignored.
REQ-028 PAUSE + start -> RUN without reloading the count (resume).
REQ-029 stop and start high in the same cycle: stop wins in RUN and PAUSE; start wins in IDLE and DONE.
REQ-030 stop in IDLE or DONE has no effect.
REQ-031 start in RUN has no effect.
REQ-032 A dir change between steps takes effect on the next step with no extra cycle.
REQ-033 The count never exceeds term while busy.
REQ-034 cfg_valid while busy is ignored, and cfg_ready stays low.

Reset
REQ-035 clr high at a rising edge forces the following values, regardless of state and other inputs.
- State: IDLE.
- count = 0, term = 2^WIDTH-1, latched oneshot = 0.
REQ-036 While clr is high: t_en = 0, tc = 0, busy = 0, done = 0, cfg_ready = 1.
REQ-037 clr asserted mid-RUN discards the count on that edge; no tc is issued for the discarded step.

Verification
REQ-038 Scenario: clr for 2 cycles, then release -> count=0, busy=0, cfg_ready=1, t_en=0.
REQ-039 Scenario: cfg mod_val=5, start with oneshot=0, dir=0, then 7 steps -> count 1,2,3,4,5,0,1.
- tc pulses on the 6th step only.
- t_en on the 6th step = 8'h05.
REQ-040 Scenario: cfg mod_val=3, oneshot=1, dir=1, start, then 5 steps -> count 2,1,0,3.
- tc and the DONE transition occur on the 4th step.
- The 5th step is ignored and done=1.
REQ-041 Scenario: running, stop and start in the same cycle -> PAUSE; then start -> RUN with the count unchanged.
REQ-042 Scenario: cfg_valid with mod_val=9 while busy -> term unchanged.
- Then the same handshake in IDLE with mod_val=0 -> an up-count wraps at 255 with tc.
REQ-043 Scenario: clr asserted on a wrapping step -> count=0, tc=0 after the edge, state IDLE.

Source files
------------

// File: rtl/tff_count_ctrl.sv
// Controller for a WIDTH-bit toggle-flip-flop bank counting 0..term, up or down, with pause/resume and oneshot.
// t_en and tc are combinational from the step that causes them; state, count and status flags are registered.
module tff_count_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] mod_val,
    input  logic             oneshot,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             dir,
    output logic [WIDTH-1:0] t_en,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic [WIDTH-1:0] count_nxt;
    logic             oneshot_q, oneshot_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rdy_q, rdy_d;
    logic             adv;
    logic             wrap;

    always_comb begin
        term_d = term_q;
        if (cfg_valid && rdy_q) begin
            term_d = (mod_val == '0) ? '1 : mod_val;
        end

        // A stop in the same cycle as a step pauses without advancing.
        adv  = (state_q == RUN) && step && !stop;
        wrap = dir ? (count_q == '0) : (count_q == term_q);
        if (dir) begin
            count_nxt = wrap ? term_q : count_q - ONE;
        end else begin
            count_nxt = wrap ? '0 : count_q + ONE;
        end

        state_d   = state_q;
        count_d   = count_q;
        oneshot_d = oneshot_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    count_d   = dir ? term_d : '0;
                    oneshot_d = oneshot;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = PAUSE;
                end else if (step) begin
                    count_d = count_nxt;
                    if (wrap && oneshot_q) begin
                        state_d = DONE;
                    end
                end
            end
            PAUSE: begin
                if (!stop && start) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == PAUSE);
        done_d = (state_d == DONE);
        rdy_d  = (state_d == IDLE) || (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            count_q   <= '0;
            term_q    <= '1;
            oneshot_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdy_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            term_q    <= term_d;
            oneshot_q <= oneshot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdy_q     <= rdy_d;
        end
    end

    // clr masks the status outputs immediately rather than one edge later.
    assign t_en      = (adv && !clr) ? (count_q ^ count_nxt) : '0;
    assign tc        = adv && wrap && !clr;
    assign count     = count_q;
    assign busy      = busy_q && !clr;
    assign done      = done_q && !clr;
    assign cfg_ready = rdy_q || clr;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Bench for tff_count_ctrl: directed scenarios then random traffic against an arithmetic reference model.
module tb_tff_count_ctrl;

    localparam int W    = 8;
    localparam int MAXV = 255;

    logic         clk;
    logic         clr, cfg_valid, oneshot, start, stop, step, dir;
    logic [W-1:0] mod_val;
    logic         cfg_ready, tc, busy, done;
    logic [W-1:0] t_en, count;

    tff_count_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .mod_val  (mod_val),
        .oneshot  (oneshot),
        .start    (start),
        .stop     (stop),
        .step     (step),
        .dir      (dir),
        .t_en     (t_en),
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: mode 0=idle 1=run 2=pause 3=done
    int m_mode = 0;
    int m_cnt  = 0;
    int m_term = MAXV;
    bit m_one  = 0;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] last_ten;
    logic         last_tc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit c, input bit cv, input int mv, input bit os,
                         input bit st, input bit sp, input bit stp, input bit d);
        bit idle_like, advance, wrapped;
        int nxt, new_term;
        clr = c; cfg_valid = cv; mod_val = mv[W-1:0]; oneshot = os;
        start = st; stop = sp; step = stp; dir = d;
        @(negedge clk);
        idle_like = (m_mode == 0) || (m_mode == 3);
        advance   = !c && (m_mode == 1) && stp && !sp;
        nxt       = d ? (m_cnt + m_term) % (m_term + 1) : (m_cnt + 1) % (m_term + 1);
        wrapped   = d ? (m_cnt == 0) : (m_cnt == m_term);
        chk("cfg_ready", cfg_ready, c || idle_like);
        chk("busy", busy, !c && (m_mode == 1 || m_mode == 2));
        chk("done", done, !c && m_mode == 3);
        chk("tc", tc, advance && wrapped);
        chk("t_en", t_en, advance ? (m_cnt ^ nxt) : 0);
        if (!c) chk("count", count, m_cnt);
        last_ten = t_en;
        last_tc  = tc;
        @(posedge clk);
        if (c) begin
            m_mode = 0; m_cnt = 0; m_term = MAXV; m_one = 0;
        end else begin
            new_term = m_term;
            if (cv && idle_like) new_term = (mv == 0) ? MAXV : mv;
            case (m_mode)
                0, 3: if (st) begin
                    m_mode = 1; m_cnt = d ? new_term : 0; m_one = os;
                end
                1: if (sp) m_mode = 2;
                   else if (stp) begin
                       m_cnt = nxt;
                       if (wrapped && m_one) m_mode = 3;
                   end
                default: if (!sp && st) m_mode = 1;
            endcase
            m_term = new_term;
        end
        #1;
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic steps(input int n, input bit d);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 1, d);
    endtask

    initial begin
        clr = 1; cfg_valid = 0; mod_val = '0; oneshot = 0;
        start = 0; stop = 0; step = 0; dir = 0;

        // Reset for two cycles, then release.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle_cyc(1);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_ready, 1);

        // Up count, term 5, continuous.
        drive(0, 1, 5, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        chk("up_load", count, 0);
        steps(5, 0);
        chk("up_cnt5", count, 5);
        steps(1, 0);
        chk("up_tc6", last_tc, 1);
        chk("up_ten6", last_ten, 8'h05);
        chk("up_wrap", count, 0);
        steps(1, 0);
        chk("up_cnt7", count, 1);
        chk("up_tc7", last_tc, 0);

        // Down count, term 3, oneshot.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 3, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0, 1);
        chk("dn_load", count, 3);
        steps(3, 1);
        chk("dn_cnt0", count, 0);
        steps(1, 1);
        chk("dn_tc4", last_tc, 1);
        chk("dn_done", done, 1);
        chk("dn_wrap", count, 3);
        steps(1, 1);
        chk("dn_ign_cnt", count, 3);
        chk("dn_ign_tc", last_tc, 0);

        // Stop+start together while running pauses; start resumes without reload.
        drive(0, 1, 7, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        steps(3, 0);
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        chk("pause_busy", busy, 1);
        steps(2, 0);
        chk("pause_hold", count, 3);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        chk("resume_cnt", count, 3);

        // Config offered while busy must be ignored: term stays 7.
        drive(0, 1, 9, 0, 0, 0, 0, 0);
        chk("busy_noready", cfg_ready, 0);
        steps(5, 0);
        chk("busy_term_tc", last_tc, 1);
        chk("busy_term_cnt", count, 0);

        // mod_val 0 means full range.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        steps(255, 0);
        chk("full_255", count, 255);
        steps(1, 0);
        chk("full_tc", last_tc, 1);
        chk("full_wrap", count, 0);

        // clr on a wrapping step: no tc, count cleared.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 2, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        steps(2, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        chk("clrwrap_tc", last_tc, 0);
        idle_cyc(1);
        chk("clrwrap_cnt", count, 0);
        chk("clrwrap_busy", busy, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6)),
                  $urandom_range(0, 1),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
